// File: rtl/io_peripheral_v1_pkg.sv
// Shared register map, reset constants and seven-segment decode for io_peripheral_v1.
// Build macro consumed by the block: IO_PERIPH_DEBOUNCE_EN.
package io_periph_pkg_v1;

    localparam logic [4:0] OFF_SWITCH    = 5'h00;
    localparam logic [4:0] OFF_BTN_LEVEL = 5'h04;
    localparam logic [4:0] OFF_BTN_EVENT = 5'h08;
    localparam logic [4:0] OFF_HEX       = 5'h0C;
    localparam logic [4:0] OFF_DISP_CTRL = 5'h10;

    localparam logic [31:0] HEX_RST       = 32'h0000_0000;
    localparam logic [7:0]  DISP_CTRL_RST = 8'hFF;
    localparam logic [6:0]  SEG_BLANK     = 7'h7F;
    localparam logic [6:0]  SEG_RST       = 7'h40;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/io_peripheral_v1_debounce.sv
// One button: 2-flop synchronizer, plus a stability counter when IO_PERIPH_DEBOUNCE_EN is defined.
module debounce_v1
    import io_periph_pkg_v1::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 32'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    logic meta_r;
    logic sync_r;

    if (DEBOUNCE_CYCLES < 32'd1) begin : g_bad_cfg
        $error("debounce_v1: DEBOUNCE_CYCLES must be at least 1");
    end

    // Two-stage synchronizer for the asynchronous button input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= raw;
            sync_r <= meta_r;
        end
    end

`ifdef IO_PERIPH_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 32'd1);

    logic [CW-1:0] cnt_r;
    logic          db_r;

    // Accept a new level only after it has differed from the current one for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CW{1'b0}};
            db_r  <= 1'b0;
        end else if (sync_r != db_r) begin
            if (cnt_r == CW'(DEBOUNCE_CYCLES - 32'd1)) begin
                db_r  <= sync_r;
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(32'd1);
            end
        end else begin
            cnt_r <= {CW{1'b0}};
        end
    end

    assign level = db_r;
`else
    assign level = sync_r;
`endif

endmodule

// File: rtl/io_peripheral_v1.sv
// Memory-mapped switches / buttons / seven-segment peripheral in a 32-byte window.
// Build macro: IO_PERIPH_DEBOUNCE_EN enables the per-button debounce counters.
module io_peripheral_v1
    import io_periph_pkg_v1::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
    parameter int unsigned DEBOUNCE_CYCLES = 32'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic [15:0] switch_array,
    input  logic        button0,
    input  logic        button1,
    input  logic        button2,
    input  logic        button3,
    output logic [6:0]  seg0,
    output logic [6:0]  seg1,
    output logic [6:0]  seg2,
    output logic [6:0]  seg3,
    output logic [6:0]  seg4,
    output logic [6:0]  seg5,
    output logic [6:0]  seg6,
    output logic [6:0]  seg7
);

    logic [15:0]     sw_meta_r;
    logic [15:0]     sw_sync_r;
    logic [3:0]      btn_raw_s;
    logic [3:0]      btn_db_s;
    logic [3:0]      btn_prev_r;
    logic [3:0]      btn_rise_s;
    logic [3:0]      btn_event_r;
    logic [3:0]      btn_event_nx_s;
    logic [31:0]     hex_r;
    logic [31:0]     hex_nx_s;
    logic [7:0]      disp_ctrl_r;
    logic [7:0]      disp_ctrl_nx_s;
    logic [31:0]     rd_mux_s;
    logic [31:0]     rd_data_r;
    logic            rd_valid_r;
    logic [7:0][6:0] seg_r;
    logic [7:0][6:0] seg_nx_s;
    logic            hit_s;
    logic            wr_hit_s;
    logic            rd_hit_s;
    logic [4:0]      off_s;

    assign hit_s      = (addr[31:5] == BASE_ADDR[31:5]) && (addr[1:0] == 2'b00);
    assign wr_hit_s   = wr_en && hit_s;
    assign rd_hit_s   = rd_en && hit_s;
    assign off_s      = addr[4:0];
    assign btn_raw_s  = {button3, button2, button1, button0};
    assign btn_rise_s = btn_db_s & ~btn_prev_r;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        debounce_v1 #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw_s[i]),
            .level(btn_db_s[i])
        );
    end

    // Register next-state; a press edge always survives a same-cycle W1C.
    always_comb begin
        hex_nx_s       = hex_r;
        disp_ctrl_nx_s = disp_ctrl_r;
        btn_event_nx_s = btn_event_r | btn_rise_s;
        if (wr_hit_s) begin
            case (off_s)
                OFF_HEX:       hex_nx_s       = wr_data;
                OFF_DISP_CTRL: disp_ctrl_nx_s = wr_data[7:0];
                OFF_BTN_EVENT: btn_event_nx_s = (btn_event_r & ~wr_data[3:0]) | btn_rise_s;
                default: begin
                    hex_nx_s       = hex_r;
                    disp_ctrl_nx_s = disp_ctrl_r;
                end
            endcase
        end else begin
            hex_nx_s       = hex_r;
            disp_ctrl_nx_s = disp_ctrl_r;
        end
    end

    // Segments decoded from next-state so the registered digits track a store one cycle later.
    always_comb begin
        seg_nx_s = {8{SEG_RST}};
        for (int k = 0; k < 8; k++) begin
            if (disp_ctrl_nx_s[k]) begin
                seg_nx_s[k] = hex_to_seg(hex_nx_s[4*k +: 4]);
            end else begin
                seg_nx_s[k] = SEG_BLANK;
            end
        end
    end

    // Load data mux; unmapped offsets read as zero.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (off_s)
            OFF_SWITCH:    rd_mux_s = {16'h0000, sw_sync_r};
            OFF_BTN_LEVEL: rd_mux_s = {28'h000_0000, btn_db_s};
            OFF_BTN_EVENT: rd_mux_s = {28'h000_0000, btn_event_r};
            OFF_HEX:       rd_mux_s = hex_r;
            OFF_DISP_CTRL: rd_mux_s = {24'h00_0000, disp_ctrl_r};
            default:       rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Architectural state, switch synchronizer and registered bus/segment outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta_r   <= 16'h0000;
            sw_sync_r   <= 16'h0000;
            btn_prev_r  <= 4'h0;
            btn_event_r <= 4'h0;
            hex_r       <= HEX_RST;
            disp_ctrl_r <= DISP_CTRL_RST;
            rd_data_r   <= 32'h0000_0000;
            rd_valid_r  <= 1'b0;
            seg_r       <= {8{SEG_RST}};
        end else begin
            sw_meta_r   <= switch_array;
            sw_sync_r   <= sw_meta_r;
            btn_prev_r  <= btn_db_s;
            btn_event_r <= btn_event_nx_s;
            hex_r       <= hex_nx_s;
            disp_ctrl_r <= disp_ctrl_nx_s;
            rd_valid_r  <= rd_hit_s;
            seg_r       <= seg_nx_s;
            if (rd_hit_s) begin
                rd_data_r <= rd_mux_s;
            end
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign seg0     = seg_r[0];
    assign seg1     = seg_r[1];
    assign seg2     = seg_r[2];
    assign seg3     = seg_r[3];
    assign seg4     = seg_r[4];
    assign seg5     = seg_r[5];
    assign seg6     = seg_r[6];
    assign seg7     = seg_r[7];

endmodule

// File: tb/tb_io_peripheral_v1.sv
// Scoreboard bench for io_peripheral_v1 with a cycle-level reference model (DEBOUNCE_CYCLES=4).
module tb_io_peripheral_v1;

    localparam int D = 4;
    localparam logic [31:0] BASE = 32'hFFFF_0000;
`ifdef IO_PERIPH_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif
    localparam int LATE = DB_EN ? D + 2 : 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wr_data = 32'h0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [15:0] switch_array = 16'h0;
    logic        button0 = 1'b0, button1 = 1'b0, button2 = 1'b0, button3 = 1'b0;
    logic [6:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

    io_peripheral_v1 #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wr_data(wr_data), .wr_en(wr_en), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .switch_array(switch_array),
        .button0(button0), .button1(button1), .button2(button2), .button3(button3),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
        .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd_last = 32'h0;

    // Reference model state (value after the most recent clock edge).
    logic [31:0] m_hex = 32'h0;
    logic [7:0]  m_ctrl = 8'hFF;
    logic [3:0]  m_evt = 4'h0, m_db = 4'h0, m_db_prev = 4'h0;
    logic [15:0] m_sw_sync = 16'h0;
    logic [3:0]  raw_a [0:4095];
    logic [15:0] sw_a  [0:4095];
    int          e = 0;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_hit(input logic [31:0] a);
        return (a[31:5] == BASE[31:5]) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        case (a[4:0])
            5'h00: return {16'h0, m_sw_sync};
            5'h04: return {28'h0, m_db};
            5'h08: return {28'h0, m_evt};
            5'h0C: return m_hex;
            5'h10: return {24'h0, m_ctrl};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int k);
        logic [3:0] n;
        n = m_hex[4*k +: 4];
        return m_ctrl[k] ? seg_tbl[n] : 7'h7F;
    endfunction

    function automatic logic [6:0] dut_seg(input int k);
        case (k)
            0: return seg0;
            1: return seg1;
            2: return seg2;
            3: return seg3;
            4: return seg4;
            5: return seg5;
            6: return seg6;
            default: return seg7;
        endcase
    endfunction

    // Advance the model across the clock edge that ended cycle e, using that cycle's inputs.
    task automatic commit();
        logic [3:0] nd, clr, rise;
        bit flip;
        raw_a[e] = {button3, button2, button1, button0};
        sw_a[e]  = switch_array;
        rise = m_db & ~m_db_prev;
        clr = 4'h0;
        if (wr_en && is_hit(addr)) begin
            case (addr[4:0])
                5'h08: clr = wr_data[3:0];
                5'h0C: m_hex = wr_data;
                5'h10: m_ctrl = wr_data[7:0];
                default: ;
            endcase
        end
        nd = m_db;
        for (int b = 0; b < 4; b++) begin
            if (DB_EN) begin
                // a level is taken once the last D synchronized samples all oppose it
                if (e >= D + 1) begin
                    flip = 1'b1;
                    for (int j = e - D - 1; j <= e - 2; j++) if (raw_a[j][b] == m_db[b]) flip = 1'b0;
                    if (flip) nd[b] = ~m_db[b];
                end
            end else begin
                nd[b] = (e >= 1) ? raw_a[e-1][b] : 1'b0;
            end
        end
        m_sw_sync = (e >= 1) ? sw_a[e-1] : 16'h0;
        m_evt = (m_evt & ~clr) | rise;
        m_db_prev = m_db;
        m_db = nd;
        e++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        commit();
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic cyc(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        wr_en = w;
        rd_en = r;
        addr = a;
        wr_data = d;
        if (r && is_hit(a)) exp_q.push_back(model_read(a));
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, BASE, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        exp_q.delete();
        rd_last = 32'h0;
        m_hex = 32'h0; m_ctrl = 8'hFF; m_evt = 4'h0; m_db = 4'h0; m_db_prev = 4'h0; m_sw_sync = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        e = 0;
    endtask

    // Monitor: pops the scoreboard on rd_valid and tracks the displayed digits.
    always @(negedge clk) begin
        if (!rst) begin
            check("reset_rd_valid", {31'h0, rd_valid}, 32'h0);
            check("reset_rd_data", rd_data, 32'h0);
            for (int k = 0; k < 8; k++) check("reset_seg", {25'h0, dut_seg(k)}, 32'h40);
        end else begin
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_rd_valid", {31'h0, rd_valid}, 32'h0);
                end else begin
                    rd_last = exp_q.pop_front();
                    check("rd_data", rd_data, rd_last);
                end
            end else begin
                check("rd_data_hold", rd_data, rd_last);
            end
            for (int k = 0; k < 8; k++) check("seg", {25'h0, dut_seg(k)}, {25'h0, exp_seg(k)});
        end
    end

    logic [3:0] bval;
    logic [31:0] a, d;
    int sel;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        e = 0;

        cyc(1'b0, 1'b1, BASE + 32'h10, 32'h0);
        idle(1);
        // hex pattern and its decoded digits
        cyc(1'b1, 1'b0, BASE + 32'h0C, 32'h89AB_CDEF);
        check("seg0_hex", {25'h0, seg0}, 32'h0E);
        check("seg3_hex", {25'h0, seg3}, 32'h46);
        check("seg7_hex", {25'h0, seg7}, 32'h00);
        cyc(1'b0, 1'b1, BASE + 32'h0C, 32'h0);
        idle(1);

        // short glitch, then a sustained press
        button0 = 1'b1;
        idle(3);
        button0 = 1'b0;
        idle(12);
        cyc(1'b0, 1'b1, BASE + 32'h08, 32'h0);
        cyc(1'b1, 1'b0, BASE + 32'h08, 32'hF);
        button0 = 1'b1;
        idle(10);
        cyc(1'b0, 1'b1, BASE + 32'h04, 32'h0);
        cyc(1'b0, 1'b1, BASE + 32'h08, 32'h0);
        button0 = 1'b0;
        idle(12);

        // W1C colliding with the event-set edge, then a clean clear
        cyc(1'b1, 1'b0, BASE + 32'h08, 32'h1);
        button0 = 1'b1;
        idle(LATE);
        cyc(1'b1, 1'b0, BASE + 32'h08, 32'h1);
        cyc(1'b0, 1'b1, BASE + 32'h08, 32'h0);
        check("evt_collision_kept", {31'h0, dut.btn_event_r[0]}, 32'h1);
        button0 = 1'b0;
        idle(12);
        cyc(1'b1, 1'b0, BASE + 32'h08, 32'h1);
        cyc(1'b0, 1'b1, BASE + 32'h08, 32'h0);

        // digit-enable mask
        cyc(1'b1, 1'b0, BASE + 32'h10, 32'h0000_000F);
        check("seg4_blank", {25'h0, seg4}, 32'h7F);
        check("seg7_blank", {25'h0, seg7}, 32'h7F);
        check("seg0_kept", {25'h0, seg0}, 32'h0E);

        // unmapped, out-of-window, switches, same-cycle read+write
        cyc(1'b0, 1'b1, BASE + 32'h14, 32'h0);
        cyc(1'b0, 1'b1, 32'h0000_0010, 32'h0);
        switch_array = 16'hA5A5;
        idle(2);
        cyc(1'b0, 1'b1, BASE, 32'h0);
        cyc(1'b1, 1'b1, BASE + 32'h0C, 32'h1234_5678);
        cyc(1'b0, 1'b1, BASE + 32'h0C, 32'h0);

        // reset landing on a pending rd_valid
        cyc(1'b0, 1'b1, BASE + 32'h0C, 32'h0);
        do_reset();
        idle(2);

        // randomized traffic with wandering buttons and switches
        bval = 4'h0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) bval = bval ^ (4'h1 << $urandom_range(0, 3));
            {button3, button2, button1, button0} = bval;
            if ($urandom_range(0, 15) == 0) switch_array = 16'($urandom);
            sel = int'($urandom_range(0, 9));
            a = BASE + 32'($urandom_range(0, 7) * 4);
            if (sel == 7) a = a + 32'($urandom_range(1, 3));
            if (sel == 8) a = 32'h1000_0000 + 32'($urandom_range(0, 7) * 4);
            d = $urandom;
            cyc(($urandom_range(0, 2) == 0) && sel != 9, ($urandom_range(0, 1) == 1) && sel != 9, a, d);
        end

        idle(4);
        check("queue_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
